alu_seq: RTL and testbench
==========================

# alu_seq

Sequenced execute/write-back stage that sits around the 4×8-bit dual-read-port register file.
- Accepts one register-to-register instruction per handshake.
- Drives the file's read address/enable ports and captures the two operands.
- Computes an 8-bit ALU result with Z/C flags and drives the file's write port for exactly one cycle.
- Serialises every access, so no read/write hazard can occur in the register file.

## Interface
Parameters:
- W, 8, data width; must match register-file width.
- AW, 2, register address width (4 registers).

Ports (clock/reset: one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept (IDLE only).
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV(A), 6 LDI, 7 CMP.
- in_dst  in  AW  destination register.
- in_srca, in_srcb  in  AW  source registers.
- in_imm  in  W  immediate for LDI.
- RAA, RBA  out  AW  to register-file read addresses.
- RAE, RBE  out  1  to register-file read enables.
- portA, portB  in  W  from register-file read data.
- D  out  W  write data to register file.
- WA  out  AW  write address.
- WE  out  1  write enable, one-cycle pulse.
- flag_z, flag_c  out  1  sticky flags from last executed instruction.
- done  out  1  one-cycle pulse when an instruction retires.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch op/dst/srca/srcb/imm and go to READ.
  - READ: RAA=srca, RBA=srcb, RAE=RBE=1. At the closing edge, capture portA/portB into opa/opb. Go to EXEC.
  - EXEC: compute the registered result and flags from opa/opb; RAE/RBE return to 0. Go to WB.
  - WB: WE=1 (CMP: WE=0), D=result, WA=dst, done=1. Go to IDLE.
- RAE/RBE are 0 outside READ, and RAA/RBA hold 0 outside READ. Each READ therefore toggles enable/address, forcing the file's read ports to re-evaluate.
- Arithmetic uses a 9-bit internal sum:
  - ADD: result = (opa+opb)[7:0]; C = sum[8].
  - SUB and CMP: result = (opa−opb)[7:0]; C = 1 when opa<opb (borrow).
  - AND/OR/XOR/MOV: C = 0.
  - LDI: result = imm; C = 0; operands are ignored, but READ still occurs so latency is uniform.
- Z = (result==0) for all ops, including CMP.
- Flags update only at the EXEC→WB edge and hold otherwise.
- in_valid is ignored outside IDLE; the upstream must hold its payload until in_ready&in_valid.
- dst equal to srca/srcb is legal: operands are captured in READ, and the write lands at the end of WB.

## Timing
- Handshake at edge 0 → READ in cycle 1 → EXEC in cycle 2 → WB in cycle 3 (WE, done high) → register file updated at edge 4 → IDLE in cycle 4.
- Throughput is 1 instruction per 4 cycles. Back-to-back instructions are accepted in cycle 4, and READ in cycle 5 sees the new value.
- All outputs are registered except in_ready = (state==IDLE) & ~rst.
- Reset values: state IDLE; RAA=RBA=0, RAE=RBE=0, D=0, WA=0, WE=0, done=0, flag_z=0, flag_c=0, opa=opb=0.
- Reset mid-operation aborts immediately. No WE is issued after rst rises, even from WB; the instruction is lost.
- Clock edge coincident with rst deassertion: FSM stays in IDLE for that edge.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_ADD..OP_CMP).
  - state encoding (IDLE, READ, EXEC, WB; 2-bit).
  - W/AW defaults.
- One natural sub-module: alu_core, a combinational unit taking op, opa, opb, imm and returning result, z, c. The FSM and registers live in alu_seq.
- Top-level integration instantiates alu_seq and regfile side by side, wiring RAA/RBA/RAE/RBE/portA/portB/D/WA/WE directly.

## Test plan
- Reset then LDI r0,0x5A; LDI r1,0xA6 → WE at cycle 3 of each with D=0x5A/WA=0, then D=0xA6/WA=1; done pulses twice.
- ADD r2=r0+r1 (0x5A+0xA6) → D=0x00, WA=2, flag_z=1, flag_c=1.
- SUB r3=r0−r1 → D=0xB4, flag_c=1, flag_z=0. Then CMP r1,r1 → WE stays 0, flag_z=1, flag_c=0, done=1.
- AND/OR/XOR/MOV on r0,r1 → 0x02/0xFE/0xFC/0x5A, each with C=0. MOV r0→r0 leaves r0=0x5A.
- in_valid held high continuously with changing payload → in_ready only in IDLE; exactly one instruction per 4 cycles; payloads offered during busy cycles are ignored.
- Assert rst during WB of ADD r2 → WE drops the same cycle and r2 stays unchanged. All outputs go to their reset values, and the next instruction executes normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encoding and width defaults for the
//             sequenced execute/write-back stage.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Default widths; must match the attached 4x8 register file
  localparam int W_DEF  = 8;
  localparam int AW_DEF = 2;

  // Opcode space (3 bits, fully populated)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  // Sequencer states; one instruction takes exactly one pass around the ring
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // CMP only updates flags; every other opcode writes its result back
  function automatic logic op_writes(input logic [2:0] op);
    return (op != OP_CMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_seq_if
//  Purpose  : Bundles the instruction handshake, the register-file read/write
//             ports and the status outputs of alu_seq.
//             master = environment (upstream issuer plus register file),
//             slave  = the alu_seq stage itself.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int W  = 8,
  parameter int AW = 2
);

  // Instruction handshake
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_dst;
  logic [AW-1:0] in_srca;
  logic [AW-1:0] in_srcb;
  logic [W-1:0]  in_imm;

  // Register-file read ports
  logic [AW-1:0] RAA;
  logic [AW-1:0] RBA;
  logic          RAE;
  logic          RBE;
  logic [W-1:0]  portA;
  logic [W-1:0]  portB;

  // Register-file write port
  logic [W-1:0]  D;
  logic [AW-1:0] WA;
  logic          WE;

  // Status
  logic          flag_z;
  logic          flag_c;
  logic          done;

  modport master (
    output in_valid, in_op, in_dst, in_srca, in_srcb, in_imm, portA, portB,
    input  in_ready, RAA, RBA, RAE, RBE, D, WA, WE, flag_z, flag_c, done
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_srca, in_srcb, in_imm, portA, portB,
    output in_ready, RAA, RBA, RAE, RBE, D, WA, WE, flag_z, flag_c, done
  );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational 8-op ALU producing result plus Z/C flags.
//             C is carry-out for ADD, borrow (opa<opb) for SUB/CMP, else 0.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result,
  output logic         z,
  output logic         c
);

  // One extra bit so the top bit is the carry (ADD) or the borrow (SUB)
  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // Opcode decode; logical ops and LDI never produce a carry
  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        c      = sum[W];
      end
      OP_SUB, OP_CMP: begin
        result = diff[W-1:0];
        c      = diff[W];
      end
      OP_AND: result = opa & opb;
      OP_OR:  result = opa | opb;
      OP_XOR: result = opa ^ opb;
      OP_MOV: result = opa;
      OP_LDI: result = imm;
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Four-cycle execute/write-back sequencer wrapped around a
//             dual-read-port register file. Reads both operands, runs them
//             through alu_core and issues a single-cycle write pulse. All
//             accesses are serialised, so the file never sees a hazard.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  state_t        state;

  // Latched instruction payload
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [W-1:0]  imm_q;

  // Operands captured at the end of READ
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;

  // Registered outputs
  logic [AW-1:0] raa;
  logic [AW-1:0] rba;
  logic          rae;
  logic          rbe;
  logic [W-1:0]  d;
  logic [AW-1:0] wa;
  logic          we;
  logic          done_q;
  logic          fz;
  logic          fc;

  // ALU outputs, consumed only in EXEC
  logic [W-1:0]  alu_result;
  logic          alu_z;
  logic          alu_c;

  alu_core #(
    .W (W)
  ) u_core (
    .op     (op_q),
    .opa    (opa),
    .opb    (opb),
    .imm    (imm_q),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  // Ready is the only combinational output; masked by rst so nothing is
  // accepted while the stage is held in reset
  assign bus.in_ready = (state == IDLE) & ~rst;

  assign bus.RAA    = raa;
  assign bus.RBA    = rba;
  assign bus.RAE    = rae;
  assign bus.RBE    = rbe;
  assign bus.D      = d;
  assign bus.WA     = wa;
  assign bus.WE     = we;
  assign bus.done   = done_q;
  assign bus.flag_z = fz;
  assign bus.flag_c = fc;

  // Sequencer: IDLE -> READ -> EXEC -> WB, registering every driven output.
  // Read address/enable are set on entry to READ and cleared on exit, so each
  // READ toggles them and the file's read ports re-evaluate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      dst_q  <= '0;
      imm_q  <= '0;
      opa    <= '0;
      opb    <= '0;
      raa    <= '0;
      rba    <= '0;
      rae    <= 1'b0;
      rbe    <= 1'b0;
      d      <= '0;
      wa     <= '0;
      we     <= 1'b0;
      done_q <= 1'b0;
      fz     <= 1'b0;
      fc     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            dst_q <= bus.in_dst;
            imm_q <= bus.in_imm;
            raa   <= bus.in_srca;
            rba   <= bus.in_srcb;
            rae   <= 1'b1;
            rbe   <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          opa   <= bus.portA;
          opb   <= bus.portB;
          raa   <= '0;
          rba   <= '0;
          rae   <= 1'b0;
          rbe   <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          d      <= alu_result;
          fz     <= alu_z;
          fc     <= alu_c;
          wa     <= dst_q;
          we     <= op_writes(op_q);
          done_q <= 1'b1;
          state  <= WB;
        end
        WB: begin
          we     <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq with a behavioural register
//             file and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  alu_seq_if #(.W(8), .AW(2)) bus ();

  alu_seq #(.W(8), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file attached to the stage: gated combinational read, write at edge
  logic [7:0] rf [4];
  assign bus.portA = bus.RAE ? rf[bus.RAA] : 8'h00;
  assign bus.portB = bus.RBE ? rf[bus.RBA] : 8'h00;
  always @(posedge clk) if (bus.WE === 1'b1) rf[bus.WA] <= bus.D;

  // Reference architectural state
  logic [7:0] ref_rf [4];

  typedef struct {
    logic       rd_en_a, rd_en_b, busy_rdy;
    logic [1:0] rd_a, rd_b;
    logic       exec_en, exec_we;
    logic       wb_we, wb_done, wb_fz, wb_fc;
    logic [7:0] wb_d;
    logic [1:0] wb_wa;
    logic       idle_rdy, idle_we, idle_done;
    bit         timeout;
  } obs_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] dst, sa, sb;
    logic [7:0] imm;
  } instr_t;

  // Instruction semantics in plain arithmetic: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 MOV 6 LDI 7 CMP
  function automatic void model_exec(input logic [2:0] op, input logic [7:0] a, b, imm,
                                     output logic [7:0] res, output logic z, c, wr);
    int unsigned ai, bi;
    ai = a; bi = b;
    c = 1'b0; wr = 1'b1; res = 8'h00;
    case (op)
      3'd0: begin res = 8'((ai + bi) % 256); c = (ai + bi) > 255; end
      3'd1, 3'd7: begin res = 8'((ai + 256 - bi) % 256); c = (ai < bi); wr = (op != 3'd7); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = a;
      3'd6: res = imm;
      default: res = 8'h00;
    endcase
    z = (res == 8'h00);
  endfunction

  task automatic model_step(input instr_t i, output logic [7:0] res, output logic z, c, wr);
    model_exec(i.op, ref_rf[i.sa], ref_rf[i.sb], i.imm, res, z, c, wr);
    if (wr) ref_rf[i.dst] = res;
  endtask

  // Issue one instruction from a negedge in IDLE and sample each phase
  task automatic do_instr(input instr_t i, output obs_t o);
    int n;
    n = 0;
    o.timeout = 1'b0;
    while (bus.in_ready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    if (n >= 16) o.timeout = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = i.op; bus.in_dst = i.dst; bus.in_srca = i.sa; bus.in_srcb = i.sb; bus.in_imm = i.imm;
    @(negedge clk);
    bus.in_valid = 1'b0;
    o.rd_en_a = bus.RAE; o.rd_en_b = bus.RBE; o.rd_a = bus.RAA; o.rd_b = bus.RBA;
    o.busy_rdy = bus.in_ready;
    @(negedge clk);
    o.exec_en = bus.RAE | bus.RBE; o.exec_we = bus.WE;
    @(negedge clk);
    o.wb_we = bus.WE; o.wb_done = bus.done; o.wb_d = bus.D; o.wb_wa = bus.WA;
    o.wb_fz = bus.flag_z; o.wb_fc = bus.flag_c;
    @(negedge clk);
    o.idle_rdy = bus.in_ready; o.idle_we = bus.WE; o.idle_done = bus.done;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_dst = 2'd0;
    bus.in_srca = 2'd0; bus.in_srcb = 2'd0; bus.in_imm = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", bus.in_ready); end
    checks++;
    if ({bus.RAA, bus.RBA, bus.RAE, bus.RBE} !== 6'b0) begin
      errors++; $display("FAIL reset_read_port: got %b want 000000", {bus.RAA, bus.RBA, bus.RAE, bus.RBE});
    end
    checks++;
    if ({bus.D, bus.WA, bus.WE} !== 11'b0) begin
      errors++; $display("FAIL reset_write_port: got %h want 000", {bus.D, bus.WA, bus.WE});
    end
    checks++;
    if ({bus.done, bus.flag_z, bus.flag_c} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b want 000", {bus.done, bus.flag_z, bus.flag_c});
    end
    @(negedge clk);
  endtask

  // Known-answer sequence from fixed constants
  task automatic test_directed_ops;
    instr_t     prog  [9];
    logic [7:0] exp_d [9];
    logic [2:0] exp_wzc [9];
    obs_t o;
    logic [7:0] r; logic z, c, wr;
    prog = '{ '{3'd6,2'd0,2'd0,2'd0,8'h5A}, '{3'd6,2'd1,2'd0,2'd0,8'hA6},
              '{3'd0,2'd2,2'd0,2'd1,8'h00}, '{3'd1,2'd3,2'd0,2'd1,8'h00},
              '{3'd7,2'd0,2'd1,2'd1,8'h00}, '{3'd2,2'd2,2'd0,2'd1,8'h00},
              '{3'd3,2'd3,2'd0,2'd1,8'h00}, '{3'd4,2'd2,2'd0,2'd1,8'h00},
              '{3'd5,2'd0,2'd0,2'd0,8'h00} };
    exp_d   = '{8'h5A, 8'hA6, 8'h00, 8'hB4, 8'h00, 8'h02, 8'hFE, 8'hFC, 8'h5A};
    exp_wzc = '{3'b100, 3'b100, 3'b111, 3'b101, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    for (int k = 0; k < 9; k++) begin
      do_instr(prog[k], o);
      model_step(prog[k], r, z, c, wr);
      checks++;
      if (o.timeout) begin errors++; $display("FAIL dir_timeout[%0d]: got timeout want ready", k); end
      checks++;
      if ({o.rd_en_a, o.rd_en_b, o.rd_a, o.rd_b, o.busy_rdy} !== {2'b11, prog[k].sa, prog[k].sb, 1'b0}) begin
        errors++; $display("FAIL dir_read[%0d]: got %b want %b", k,
          {o.rd_en_a, o.rd_en_b, o.rd_a, o.rd_b, o.busy_rdy}, {2'b11, prog[k].sa, prog[k].sb, 1'b0});
      end
      checks++;
      if (o.wb_d !== exp_d[k]) begin errors++; $display("FAIL dir_D[%0d]: got %h want %h", k, o.wb_d, exp_d[k]); end
      checks++;
      if ({o.wb_we, o.wb_fz, o.wb_fc} !== exp_wzc[k]) begin
        errors++; $display("FAIL dir_we_z_c[%0d]: got %b want %b", k, {o.wb_we, o.wb_fz, o.wb_fc}, exp_wzc[k]);
      end
      checks++;
      if ({o.wb_done, o.wb_wa} !== {1'b1, prog[k].dst}) begin
        errors++; $display("FAIL dir_done_WA[%0d]: got %b want %b", k, {o.wb_done, o.wb_wa}, {1'b1, prog[k].dst});
      end
      checks++;
      if ({o.exec_en, o.exec_we, o.idle_rdy, o.idle_we, o.idle_done} !== 5'b00100) begin
        errors++; $display("FAIL dir_phases[%0d]: got %b want 00100", k,
          {o.exec_en, o.exec_we, o.idle_rdy, o.idle_we, o.idle_done});
      end
    end
    checks++;
    if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h5AA6FCFE) begin
      errors++; $display("FAIL dir_regfile: got %h want 5aa6fcfe", {rf[0], rf[1], rf[2], rf[3]});
    end
  endtask

  task automatic test_random_ops;
    instr_t i; obs_t o;
    logic [7:0] r; logic z, c, wr;
    for (int k = 0; k < 40; k++) begin
      i.op = 3'($urandom_range(0, 7)); i.dst = 2'($urandom_range(0, 3));
      i.sa = 2'($urandom_range(0, 3)); i.sb = 2'($urandom_range(0, 3));
      i.imm = 8'($urandom_range(0, 255));
      do_instr(i, o);
      model_step(i, r, z, c, wr);
      checks++;
      if (o.timeout) begin errors++; $display("FAIL rnd_timeout[%0d]: got timeout want ready", k); end
      checks++;
      if ({o.rd_en_a, o.rd_en_b, o.rd_a, o.rd_b} !== {2'b11, i.sa, i.sb}) begin
        errors++; $display("FAIL rnd_read[%0d]: got %b want %b", k, {o.rd_en_a, o.rd_en_b, o.rd_a, o.rd_b}, {2'b11, i.sa, i.sb});
      end
      checks++;
      if ({o.wb_d, o.wb_wa, o.wb_we, o.wb_done, o.wb_fz, o.wb_fc} !== {r, i.dst, wr, 1'b1, z, c}) begin
        errors++; $display("FAIL rnd_wb[%0d] op %0d: got D=%h WA=%0d WE=%b done=%b Z=%b C=%b want D=%h WA=%0d WE=%b done=1 Z=%b C=%b",
          k, i.op, o.wb_d, o.wb_wa, o.wb_we, o.wb_done, o.wb_fz, o.wb_fc, r, i.dst, wr, z, c);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rf[k] !== ref_rf[k]) begin errors++; $display("FAIL rnd_regfile[%0d]: got %h want %h", k, rf[k], ref_rf[k]); end
    end
  endtask

  // in_valid stays high with a fresh payload every cycle
  task automatic test_busy_ignore;
    instr_t pend [$];
    instr_t i, p;
    logic [7:0] r; logic z, c, wr;
    int last_rdy, accepted, retired;
    last_rdy = -1; accepted = 0; retired = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (bus.done === 1'b1) begin
        checks++;
        if (pend.size() == 0) begin
          errors++; $display("FAIL busy_spurious_done: got done=1 want 0 at cycle %0d", cyc);
        end else begin
          p = pend.pop_front();
          model_step(p, r, z, c, wr);
          retired++;
          if ({bus.D, bus.WA, bus.WE, bus.flag_z, bus.flag_c} !== {r, p.dst, wr, z, c}) begin
            errors++; $display("FAIL busy_wb[%0d]: got %h want %h", cyc,
              {bus.D, bus.WA, bus.WE, bus.flag_z, bus.flag_c}, {r, p.dst, wr, z, c});
          end
        end
      end
      i.op = 3'($urandom_range(0, 7)); i.dst = 2'($urandom_range(0, 3));
      i.sa = 2'($urandom_range(0, 3)); i.sb = 2'($urandom_range(0, 3));
      i.imm = 8'($urandom_range(0, 255));
      if (bus.in_ready === 1'b1) begin
        checks++;
        if (last_rdy >= 0 && cyc - last_rdy != 4) begin
          errors++; $display("FAIL busy_ready_spacing: got %0d want 4", cyc - last_rdy);
        end
        last_rdy = cyc;
        pend.push_back(i);
        accepted++;
      end
      bus.in_valid = 1'b1;
      bus.in_op = i.op; bus.in_dst = i.dst; bus.in_srca = i.sa; bus.in_srcb = i.sb; bus.in_imm = i.imm;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepted != 12) begin errors++; $display("FAIL busy_accepted: got %0d want 12", accepted); end
    checks++;
    if (retired != 12) begin errors++; $display("FAIL busy_retired: got %0d want 12", retired); end
    repeat (4) @(negedge clk);
  endtask

  // Reset during WB of ADD r2 must suppress the write
  task automatic test_reset_mid;
    instr_t i; obs_t o;
    logic [7:0] r; logic z, c, wr;
    i = '{3'd6, 2'd0, 2'd0, 2'd0, 8'hF0}; do_instr(i, o); model_step(i, r, z, c, wr);
    i = '{3'd6, 2'd1, 2'd0, 2'd0, 8'h20}; do_instr(i, o); model_step(i, r, z, c, wr);
    i = '{3'd6, 2'd2, 2'd0, 2'd0, 8'h77}; do_instr(i, o); model_step(i, r, z, c, wr);
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_dst = 2'd2; bus.in_srca = 2'd0; bus.in_srcb = 2'd1;
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.WE, bus.done, bus.D, bus.flag_c} !== {2'b11, 8'h10, 1'b1}) begin
      errors++; $display("FAIL rmid_pre_wb: got %h want %h", {bus.WE, bus.done, bus.D, bus.flag_c}, {2'b11, 8'h10, 1'b1});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.WE, bus.done, bus.in_ready, bus.RAE, bus.RBE, bus.RAA, bus.RBA, bus.D, bus.WA, bus.flag_z, bus.flag_c} !== 21'b0) begin
      errors++; $display("FAIL rmid_outputs: got %h want 0",
        {bus.WE, bus.done, bus.in_ready, bus.RAE, bus.RBE, bus.RAA, bus.RBA, bus.D, bus.WA, bus.flag_z, bus.flag_c});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rf[2] !== 8'h77) begin errors++; $display("FAIL rmid_r2_kept: got %h want 77", rf[2]); end
    i = '{3'd0, 2'd3, 2'd0, 2'd1, 8'h00};
    do_instr(i, o); model_step(i, r, z, c, wr);
    checks++;
    if ({o.timeout, o.wb_we, o.wb_done, o.wb_d, o.wb_wa, o.wb_fz, o.wb_fc} !== {1'b0, 2'b11, 8'h10, 2'd3, 2'b01}) begin
      errors++; $display("FAIL rmid_after: got %h want %h",
        {o.timeout, o.wb_we, o.wb_done, o.wb_d, o.wb_wa, o.wb_fz, o.wb_fc}, {1'b0, 2'b11, 8'h10, 2'd3, 2'b01});
    end
    checks++;
    if (rf[3] !== 8'h10) begin errors++; $display("FAIL rmid_r3: got %h want 10", rf[3]); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rf[k] = 8'($urandom_range(0, 255));
      ref_rf[k] = rf[k];
    end
    test_reset();
    test_directed_ops();
    test_random_ops();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
